// File: rtl/adc_capture_user_logic_if.sv
// Bus2IP/IP2Bus slave-register bundle for the ADC capture user logic.
// Master drives chip enables and write data; slave returns read data and acks.
interface adc_capture_user_logic_if #(
    parameter int C_SLV_DWIDTH = 32,
    parameter int C_NUM_REG    = 2
);
    logic [0:C_SLV_DWIDTH-1] Bus2IP_Data;
    logic [0:3]              Bus2IP_BE;
    logic [0:C_NUM_REG-1]    Bus2IP_RdCE;
    logic [0:C_NUM_REG-1]    Bus2IP_WrCE;
    logic [0:C_SLV_DWIDTH-1] IP2Bus_Data;
    logic                    IP2Bus_RdAck;
    logic                    IP2Bus_WrAck;
    logic                    IP2Bus_Error;

    modport master (
        output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

    modport slave (
        input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );
endinterface

// File: rtl/adc_capture_user_logic.sv
// ADC capture user logic: sample clock divider, input register, sample FIFO, bus regs.
// Optional ADC_TEST_PATTERN_EN: control bit3 swaps the ADC word for a strobe counter.
module adc_capture_user_logic #(
    parameter int C_SLV_DWIDTH  = 32,
    parameter int C_NUM_REG     = 2,
    parameter int C_ADC_DWIDTH  = 10,
    parameter int C_FIFO_AWIDTH = 4,
    parameter int C_CLKDIV      = 4
) (
    input  logic                    Bus2IP_Clk,
    input  logic                    Bus2IP_Resetn,
    input  logic [0:C_ADC_DWIDTH-1] ADC2IP_Data,
    input  logic                    ADC2IP_OTR,
    output logic                    IP2ADC_Clk,
    output logic                    IP2ADC_OE_n,
    output logic                    IP2ADC_PWRDN,
    adc_capture_user_logic_if.slave bus
);
    localparam int DW    = C_ADC_DWIDTH;
    localparam int AW    = C_FIFO_AWIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = $clog2(C_CLKDIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(C_CLKDIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic          r_en;
    logic          r_pwrdn;
    logic          r_pwr_out;
    logic [CW-1:0] r_div;
    logic          r_adc_clk;
    logic [DW-1:0] r_adc_data;
    logic          r_adc_otr;
    logic [DW:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_ce_q;
    logic          r_rdack;
    logic          r_wrack;
    logic          r_err;
    logic [C_SLV_DWIDTH-1:0] r_rd_data;

    logic [C_SLV_DWIDTH-1:0] w_wdata;
    logic [C_SLV_DWIDTH-1:0] w_rdata;
    logic [3:0]    w_be;
    logic          w_rd;
    logic          w_wr;
    logic          w_start;
    logic          w_rd_go;
    logic          w_wr_go;
    logic          w_rd_reg0;
    logic          w_rd_reg1;
    logic          w_wr_reg0;
    logic          w_wr_reg1;
    logic          w_ctl_we;
    logic          w_clr;
    logic          w_run;
    logic          w_strobe;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_tpat;
    logic [DW:0]   w_src;
    logic          w_unused;

    // Big-endian bus vectors copied into LSB-indexed form: w_wdata[n] is bit n.
    assign w_wdata = bus.Bus2IP_Data;
    assign w_be    = bus.Bus2IP_BE;

    assign w_rd    = |bus.Bus2IP_RdCE;
    assign w_wr    = |bus.Bus2IP_WrCE;
    assign w_start = (w_rd | w_wr) & ~r_ce_q;
    assign w_rd_go = w_start & w_rd;
    assign w_wr_go = w_start & ~w_rd & w_wr;

    assign w_rd_reg0 = w_rd_go & bus.Bus2IP_RdCE[0];
    assign w_rd_reg1 = w_rd_go & ~bus.Bus2IP_RdCE[0] & bus.Bus2IP_RdCE[1];
    assign w_wr_reg0 = w_wr_go & bus.Bus2IP_WrCE[0];
    assign w_wr_reg1 = w_wr_go & ~bus.Bus2IP_WrCE[0] & bus.Bus2IP_WrCE[1];
    assign w_ctl_we  = w_wr_reg0 & w_be[0];
    assign w_clr     = w_ctl_we & w_wdata[1];

    assign w_run    = r_en & ~r_pwrdn;
    assign w_strobe = w_run & (r_div == DIV_LAST) & r_adc_clk;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = w_strobe & r_en & ~w_full;
    assign w_pop   = w_rd_reg1 & ~w_empty;

    assign w_unused = ^{w_wdata, w_be};

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_en      <= 1'b0;
            r_pwrdn   <= 1'b0;
            r_pwr_out <= 1'b1;
        end else if (w_ctl_we) begin
            r_en      <= w_wdata[0];
            r_pwrdn   <= w_wdata[2];
            r_pwr_out <= w_wdata[2];
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    logic          r_tpat;
    logic [DW-1:0] r_tpat_cnt;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_tpat     <= 1'b0;
            r_tpat_cnt <= '0;
        end else begin
            if (w_ctl_we)
                r_tpat <= w_wdata[3];
            // Counts every strobe, dropped or not, so gaps expose overflow.
            if (w_clr)
                r_tpat_cnt <= '0;
            else if (w_strobe)
                r_tpat_cnt <= r_tpat_cnt + 1'b1;
        end
    end

    assign w_tpat = r_tpat;
    assign w_src  = r_tpat ? {1'b0, r_tpat_cnt} : {r_adc_otr, r_adc_data};
`else
    assign w_tpat = 1'b0;
    assign w_src  = {r_adc_otr, r_adc_data};
`endif

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_div     <= '0;
            r_adc_clk <= 1'b0;
        end else if (!w_run) begin
            r_div     <= '0;
            r_adc_clk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div     <= '0;
            r_adc_clk <= ~r_adc_clk;
        end else begin
            r_div     <= r_div + 1'b1;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_adc_data <= '0;
            r_adc_otr  <= 1'b0;
        end else begin
            r_adc_data <= ADC2IP_Data;
            r_adc_otr  <= ADC2IP_OTR;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_src;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            if (w_strobe && w_full)
                r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd_reg0) begin
            w_rdata[0]          = r_en;
            w_rdata[2]          = r_pwrdn;
            w_rdata[3]          = w_empty;
            w_rdata[4]          = w_full;
            w_rdata[5]          = r_ovf;
            w_rdata[6]          = w_tpat;
            w_rdata[8 +: AW+1]  = r_count;
        end else if (w_pop) begin
            w_rdata[DW:0]           = r_mem[r_rptr];
            w_rdata[C_SLV_DWIDTH-1] = 1'b1;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_ce_q    <= 1'b0;
            r_rdack   <= 1'b0;
            r_wrack   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_ce_q    <= w_rd | w_wr;
            r_rdack   <= w_rd_go;
            r_wrack   <= w_wr_go;
            r_err     <= w_wr_reg1;
            r_rd_data <= w_rdata;
        end
    end

    assign IP2ADC_Clk   = r_adc_clk;
    assign IP2ADC_OE_n  = ~r_en;
    // Powered down from reset until software first writes the control register.
    assign IP2ADC_PWRDN = r_pwr_out;

    assign bus.IP2Bus_Data  = r_rd_data;
    assign bus.IP2Bus_RdAck = r_rdack;
    assign bus.IP2Bus_WrAck = r_wrack;
    assign bus.IP2Bus_Error = r_err;
endmodule

// File: doc/adc_capture_user_logic.md
Name: adc_capture_user_logic

Overview:
- PLB IPIF user_logic for the ADC front end; the receive-side counterpart of the DAC output path.
- Generates the ADC sample clock and registers the parallel ADC word on each sample strobe.
- Buffers samples in a small FIFO and exposes control/status and FIFO-pop registers on the Bus2IP/IP2Bus slave-register interface.
- Bus bit numbering is big-endian ([0:31], bit 31 = LSB); "bit n" below means LSB-relative, i.e. data[31-n].

Parameters:
- C_SLV_DWIDTH, 32, bus data width.
- C_NUM_REG, 2, number of CE lines (reg0 control/status, reg1 data).
- C_ADC_DWIDTH, 10, ADC sample width.
- C_FIFO_AWIDTH, 4, FIFO depth = 2**C_FIFO_AWIDTH (16).
- C_CLKDIV, 4, IP2ADC_Clk period = 2*C_CLKDIV Bus2IP_Clk cycles; legal range >= 2.

Ports:
- Bus2IP_Clk  in  1  sole clock.
- Bus2IP_Resetn  in  1  asynchronous, active-low reset.
- ADC2IP_Data  in  [0:C_ADC_DWIDTH-1]  ADC parallel output word.
- ADC2IP_OTR  in  1  ADC out-of-range flag.
- IP2ADC_Clk  out  1  ADC sample clock.
- IP2ADC_OE_n  out  1  ADC output enable, active low.
- IP2ADC_PWRDN  out  1  ADC power-down.
- Bus2IP_Data  in  [0:C_SLV_DWIDTH-1]  write data.
- Bus2IP_BE  in  [0:3]  byte enables; byte 3 (bits 7..0) must be set for control writes to take effect.
- Bus2IP_RdCE  in  [0:C_NUM_REG-1]  read chip enables; "10" = reg0, "01" = reg1.
- Bus2IP_WrCE  in  [0:C_NUM_REG-1]  write chip enables; same encoding.
- IP2Bus_Data  out  [0:C_SLV_DWIDTH-1]  read data.
- IP2Bus_RdAck  out  1  read acknowledge.
- IP2Bus_WrAck  out  1  write acknowledge.
- IP2Bus_Error  out  1  access error.

Behaviour:
- Reset values (asynchronous, Bus2IP_Resetn=0):
  - all registers 0, FIFO empty, overflow flag 0;
  - IP2ADC_Clk=0, IP2ADC_OE_n=1, IP2ADC_PWRDN=1;
  - IP2Bus_Data=0, all acks and Error 0.
- Control register (reg0 write):
  - bit0 EN: start/stop capture.
  - bit1 CLR: self-clearing; flushes the FIFO and clears overflow.
  - bit2 PWRDN: ADC power-down.
  - Other bits ignored.
- ADC outputs: IP2ADC_PWRDN = PWRDN; IP2ADC_OE_n = ~EN.
- Clock divider:
  - Counter 0..C_CLKDIV-1 runs only while EN=1 and PWRDN=0; IP2ADC_Clk toggles on wrap.
  - When EN falls, the counter and IP2ADC_Clk return to 0 on the next cycle.
- Capture path:
  - ADC2IP_Data/OTR are registered every cycle (one input stage).
  - Sample strobe = cycle on which IP2ADC_Clk toggles 1->0; the registered word is pushed on that strobe.
- FIFO:
  - Push when strobe, EN=1 and not full. If full, the sample is dropped and the overflow flag is set (sticky).
  - Simultaneous push and pop: count unchanged, both occur.
  - CLR has priority over push and pop in the same cycle.
  - Pointers wrap modulo depth; count width is C_FIFO_AWIDTH+1.
- Bus handshake:
  - Access recognised on the rising edge of any CE bit (CE registered, edge detected).
  - RdAck/WrAck is a single-cycle pulse in the cycle after the first CE cycle; IP2Bus_Data is valid with RdAck and 0 otherwise.
  - A CE held high produces exactly one ack; no new access is recognised until CE deasserts.
  - RdCE and WrCE both high: treat as a read.
- reg0 read:
  - bit0 EN, bit2 PWRDN, bit3 empty, bit4 full, bit5 overflow;
  - bits 12..8 FIFO count; other bits 0.
- reg1 read:
  - If not empty: pop one entry. Returns bits 9..0 sample, bit10 OTR, bit31 valid=1.
  - If empty: returns all zeros and no pop.
- Errors:
  - Write to reg1 is read-only: WrAck with IP2Bus_Error=1, no state change.
  - Error is otherwise 0.
- Reset mid-access or mid-capture: everything returns immediately to reset values; no ack is produced for the aborted access.

Optional Feature:
- Macro ADC_TEST_PATTERN_EN.
- Defined:
  - control bit3 TPAT selects a free-running C_ADC_DWIDTH-bit counter as the FIFO source instead of ADC2IP_Data;
  - the counter starts at 0 after reset or CLR and increments per strobe (including dropped strobes); OTR is pushed as 0;
  - TPAT reads back at reg0 bit6.
- Undefined: bit3 ignored, reg0 bit6 reads 0, no counter logic.

Test Plan:
- Reset, then read reg0 -> 0x0000_0008 (empty only); IP2ADC_OE_n=1, IP2ADC_PWRDN=1, IP2ADC_Clk=0.
- Write reg0=0x1, drive ADC2IP_Data=10'h155 -> IP2ADC_Clk period 8 cycles; after 3 strobes reg0 count=3; reg1 reads 0x8000_0155 three times, fourth read returns 0x0000_0000.
- Enable with ADC input held, no reads, for 20 strobes -> count=16, full=1, overflow=1; write reg0=0x3 -> empty, overflow 0, EN still 1.
- Hold RdCE="01" for 10 cycles with 2 entries queued -> exactly one RdAck, one pop, count goes 2->1.
- Write WrCE="01" data 0x1234_0000 -> WrAck with IP2Bus_Error=1, FIFO and control unchanged.
- With ADC_TEST_PATTERN_EN defined, write reg0=0x9 -> successive reg1 reads return 0x8000_0000, 0x8000_0001, 0x8000_0002; deassert Bus2IP_Resetn mid-stream -> all outputs return to reset values on that same edge.
